// File: rtl/edge_trap_pkg.sv
// Shared types and limits for the multi-channel edge capture unit.
package edge_trap_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2,
        EDGE_BOTH = 2'd3
    } edge_mode_t;

    localparam int unsigned MAX_SYNC_STAGES = 6;

    // True when the observed transition matches the programmed edge mode.
    function automatic logic edge_match(input edge_mode_t m, input logic rise, input logic fall);
        logic hit;
        hit = 1'b0;
        case (m)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-stage synchroniser; kept alone so metastability constraints attach in one place.
module sync_chain #(
    parameter int unsigned STAGES = 3,
    parameter int unsigned W      = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [STAGES];

    // Shift raw inputs through the chain; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/multi_edge_trap.sv
// N-channel edge capture: synchronise, detect edges, latch pending/missed,
// count events, and present the lowest pending channel to a single consumer.
module multi_edge_trap
    import edge_trap_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned SYNC_STAGES = 3,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned IDX_W       = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       async_in,
    input  logic [2*N-1:0]     mode,
    input  logic               evt_ack,
    input  logic               cnt_clr,
    output logic [N-1:0]       sync_out,
    output logic [N-1:0]       edge_pulse,
    output logic [N-1:0]       pending,
    output logic [N-1:0]       missed,
    output logic               evt_valid,
    output logic [IDX_W-1:0]   evt_chan,
    output logic [N*CNT_W-1:0] evt_count
);

    localparam int unsigned SU_MAX = SYNC_STAGES + 1;
    localparam int unsigned SU_W   = $clog2(SU_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if ((N < 1) || (N > 32)) begin : g_bad_n
        $error("multi_edge_trap: N out of range 1..32");
    end
    if ((SYNC_STAGES < 2) || (SYNC_STAGES > MAX_SYNC_STAGES)) begin : g_bad_sync
        $error("multi_edge_trap: SYNC_STAGES out of range");
    end

    logic [N-1:0]       prev_q;
    logic [N-1:0]       pulse_q;
    logic [N-1:0]       pend_q;
    logic [N-1:0]       miss_q;
    logic [SU_W-1:0]    su_q;
    logic [CNT_W-1:0]   cnt_q [N];

    logic               mask_done;
    logic [N-1:0]       qual;
    logic [N-1:0]       ack_vec;
    logic [N-1:0]       pend_d;
    logic [N-1:0]       miss_d;
    logic [CNT_W-1:0]   cnt_d [N];

    sync_chain #(
        .STAGES (SYNC_STAGES),
        .W      (N)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (async_in),
        .q     (sync_out)
    );

    // Startup mask: block edge detection until the sync chain holds real samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            su_q <= '0;
        end else if (su_q != SU_W'(SU_MAX)) begin
            su_q <= su_q + SU_W'(1);
        end
    end

    assign mask_done = (su_q == SU_W'(SU_MAX));

    // Fixed-priority arbiter: lowest-numbered pending channel wins.
    always_comb begin
        evt_valid = |pend_q;
        evt_chan  = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                evt_chan = IDX_W'(i);
            end
        end
    end

    // Edge qualification, ack decode and next-state for pending/missed/counters.
    always_comb begin
        qual    = '0;
        ack_vec = '0;
        pend_d  = pend_q;
        miss_d  = miss_q;
        for (int i = 0; i < int'(N); i++) begin
            cnt_d[i] = cnt_q[i];
        end
        for (int i = 0; i < int'(N); i++) begin
            qual[i] = mask_done &
                      edge_match(edge_mode_t'(mode[2*i +: 2]),
                                 sync_out[i] & ~prev_q[i],
                                 ~sync_out[i] & prev_q[i]);
            ack_vec[i] = evt_ack & evt_valid & (evt_chan == IDX_W'(i));
        end
        pend_d = (pend_q & ~ack_vec) | qual;
        if (cnt_clr) begin
            miss_d = '0;
        end else begin
            miss_d = miss_q | (qual & pend_q & ~ack_vec);
        end
        for (int i = 0; i < int'(N); i++) begin
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (qual[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Per-channel state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= '0;
            pulse_q <= '0;
            pend_q  <= '0;
            miss_q  <= '0;
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            prev_q  <= sync_out;
            pulse_q <= qual;
            pend_q  <= pend_d;
            miss_q  <= miss_d;
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        evt_count = '0;
        for (int i = 0; i < int'(N); i++) begin
            evt_count[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign edge_pulse = pulse_q;
    assign pending    = pend_q;
    assign missed     = miss_q;

endmodule
